// File: rtl/calc_pkg.sv
// Shared calculator definitions: button op codes, keypad key codes, keypad FSM states
// and the keypad position to key code map.
package calc_pkg;

    typedef enum logic [2:0] {
        OP_NONE = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_MUL  = 3'b011,
        OP_DIV  = 3'b100
    } op_t;

    localparam logic [3:0] KEY_ADD = 4'd10;
    localparam logic [3:0] KEY_SUB = 4'd11;
    localparam logic [3:0] KEY_MUL = 4'd12;
    localparam logic [3:0] KEY_DIV = 4'd13;
    localparam logic [3:0] KEY_EQ  = 4'd14;
    localparam logic [3:0] KEY_CLR = 4'd15;

    typedef enum logic [1:0] {
        KP_SCAN,
        KP_DEBOUNCE,
        KP_EMIT,
        KP_RELEASE
    } kp_state_t;

    // Keypad face: r0 = 1 2 3 +, r1 = 4 5 6 -, r2 = 7 8 9 *, r3 = C 0 = /
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = 4'd0;
        case ({row, col})
            4'h0: code = 4'd1;
            4'h1: code = 4'd2;
            4'h2: code = 4'd3;
            4'h3: code = KEY_ADD;
            4'h4: code = 4'd4;
            4'h5: code = 4'd5;
            4'h6: code = 4'd6;
            4'h7: code = KEY_SUB;
            4'h8: code = 4'd7;
            4'h9: code = 4'd8;
            4'hA: code = 4'd9;
            4'hB: code = KEY_MUL;
            4'hC: code = KEY_CLR;
            4'hD: code = 4'd0;
            4'hE: code = KEY_EQ;
            4'hF: code = KEY_DIV;
            default: code = 4'd0;
        endcase
        return code;
    endfunction

    function automatic op_t key_to_op(input logic [3:0] code);
        op_t op;
        op = OP_NONE;
        case (code)
            KEY_ADD: op = OP_ADD;
            KEY_SUB: op = OP_SUB;
            KEY_MUL: op = OP_MUL;
            KEY_DIV: op = OP_DIV;
            default: op = OP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/calc_sync2.sv
// Two-flop synchroniser for asynchronous inputs; resets to all-ones so idle
// pulled-up lines read as inactive.
module calc_sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/calc_keypad_encoder.sv
// 4x4 keypad scanner and debouncer; turns each accepted press into a single-cycle
// command pulse on the calculator core's button interface.
module calc_keypad_encoder
    import calc_pkg::*;
#(
    parameter int SCAN_DIV        = 16,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] button_num,
    output logic       num_valid,
    output logic [2:0] button_op,
    output logic       equal,
    output logic       key_clear,
    output logic [3:0] key_code,
    output logic       key_valid
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DWELL_EVAL = DW'(3);
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

    kp_state_t     state, state_nx;
    logic [1:0]    row, row_nx;
    logic [DW-1:0] dwell, dwell_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [1:0]    col_lat, col_lat_nx;
    logic          emit_nx;
    logic [3:0]    col_s;
    logic [3:0]    emit_code;
    logic [1:0]    low_col;
    logic          any_low;
    logic          lat_low;

    calc_sync2 #(.WIDTH(4)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (col_n),
        .q     (col_s)
    );

    always_comb begin
        any_low = (col_s != 4'b1111);
        lat_low = !col_s[col_lat];
        low_col = 2'd3;
        if (!col_s[0])      low_col = 2'd0;
        else if (!col_s[1]) low_col = 2'd1;
        else if (!col_s[2]) low_col = 2'd2;
        emit_code = key_map(row, col_lat);
    end

    // The row register doubles as the latched row: it only moves while scanning.
    always_comb begin
        state_nx   = state;
        row_nx     = row;
        dwell_nx   = dwell;
        cnt_nx     = cnt;
        col_lat_nx = col_lat;
        emit_nx    = 1'b0;
        case (state)
            KP_SCAN: begin
                if (dwell >= DWELL_EVAL && any_low) begin
                    col_lat_nx = low_col;
                    cnt_nx     = '0;
                    state_nx   = KP_DEBOUNCE;
                end else if (dwell == DWELL_LAST) begin
                    dwell_nx = '0;
                    row_nx   = row + 2'd1;
                end else begin
                    dwell_nx = dwell + 1'b1;
                end
            end
            KP_DEBOUNCE: begin
                if (!lat_low) begin
                    cnt_nx   = '0;
                    state_nx = KP_SCAN;
                end else if (cnt == DEB_LAST) begin
                    cnt_nx   = '0;
                    emit_nx  = 1'b1;
                    state_nx = KP_EMIT;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            KP_EMIT: begin
                cnt_nx   = '0;
                state_nx = KP_RELEASE;
            end
            KP_RELEASE: begin
                if (any_low) begin
                    cnt_nx = '0;
                end else if (cnt == DEB_LAST) begin
                    cnt_nx   = '0;
                    dwell_nx = '0;
                    row_nx   = row + 2'd1;
                    state_nx = KP_SCAN;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = KP_SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= KP_SCAN;
            row     <= 2'd0;
            dwell   <= '0;
            cnt     <= '0;
            col_lat <= 2'd0;
            row_n   <= 4'b1110;
        end else begin
            state   <= state_nx;
            row     <= row_nx;
            dwell   <= dwell_nx;
            cnt     <= cnt_nx;
            col_lat <= col_lat_nx;
            row_n   <= ~(4'b0001 << row_nx);
        end
    end

    // Command pulses are registered so they land in the cycle the FSM sits in EMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            button_num <= 4'd0;
            num_valid  <= 1'b0;
            button_op  <= OP_NONE;
            equal      <= 1'b0;
            key_clear  <= 1'b0;
            key_code   <= 4'd0;
            key_valid  <= 1'b0;
        end else begin
            key_valid <= emit_nx;
            num_valid <= emit_nx && (emit_code < 4'd10);
            button_op <= emit_nx ? key_to_op(emit_code) : OP_NONE;
            equal     <= emit_nx && (emit_code == KEY_EQ);
            key_clear <= emit_nx && (emit_code == KEY_CLR);
            if (emit_nx) begin
                key_code <= emit_code;
                if (emit_code < 4'd10) begin
                    button_num <= emit_code;
                end
            end
        end
    end

endmodule
